// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_EXT   = 3'd3,
      ST_WB    = 3'd4,
      ST_HALT  = 3'd5,
      ST_TRAP  = 3'd6
   } state_e;

   localparam logic [3:0] OP_MOV = 4'h0;
   localparam logic [3:0] OP_MVI = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_LDX = 4'h3;
   localparam logic [3:0] OP_NOP = 4'hC;
   localparam logic [3:0] OP_BAD1 = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hE;
   localparam logic [3:0] OP_BAD2 = 4'hF;

   localparam logic [3:0] ALU_BASE = 4'd4;

   localparam logic [3:0] LEN_1 = 4'd1;
   localparam logic [3:0] LEN_2 = 4'd2;
   localparam logic [3:0] LEN_3 = 4'd3;

   // Opcode-dependent datapath strobes (fetch strobes come from the FSM).
   typedef struct packed {
      logic       op1_load;
      logic       op2_load;
      logic       reg_load;
      logic [2:0] alu_ot;
   } dp_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: length, write-back need, legality and
// the strobes driven in EXEC and in WB.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPC_W = 4,
   parameter int LMAX  = 3
) (
   input  logic [OPC_W-1:0] opcode,
   output logic [3:0]       length,
   output logic             needs_wb,
   output logic             illegal,
   output logic             is_halt,
   output dp_ctrl_t         exec_ctl,
   output dp_ctrl_t         wb_ctl
);

   localparam logic [OPC_W-1:0] LOW_MASK = OPC_W'(15);

   logic       upper_set;
   logic [3:0] lo;

   assign upper_set = |(opcode & ~LOW_MASK);
   assign lo        = opcode[3:0];

   always_comb begin
      length   = LEN_1;
      needs_wb = 1'b0;
      illegal  = 1'b0;
      is_halt  = 1'b0;
      exec_ctl = '0;
      wb_ctl   = '0;
      if (upper_set) begin
         illegal = 1'b1;
      end else begin
         case (lo)
            OP_MOV: begin
               exec_ctl.op2_load = 1'b1;
               exec_ctl.reg_load = 1'b1;
            end
            OP_MVI: begin
               length            = LEN_2;
               needs_wb          = 1'b1;
               exec_ctl.op1_load = 1'b1;
               wb_ctl.reg_load   = 1'b1;
            end
            OP_LDA: begin
               length          = LEN_2;
               needs_wb        = 1'b1;
               wb_ctl.op1_load = 1'b1;
               wb_ctl.reg_load = 1'b1;
            end
            OP_LDX: begin
               // A 3-word instruction cannot exist on a 2-word machine.
               if (LMAX < 3) begin
                  illegal = 1'b1;
               end else begin
                  length          = LEN_3;
                  needs_wb        = 1'b1;
                  wb_ctl.op1_load = 1'b1;
                  wb_ctl.reg_load = 1'b1;
               end
            end
            OP_NOP: ;
            OP_HLT:  is_halt = 1'b1;
            OP_BAD1: illegal = 1'b1;
            OP_BAD2: illegal = 1'b1;
            default: begin
               needs_wb          = 1'b1;
               exec_ctl.op1_load = 1'b1;
               exec_ctl.op2_load = 1'b1;
               exec_ctl.alu_ot   = 3'(lo - ALU_BASE);
               wb_ctl.reg_load   = 1'b1;
               wb_ctl.alu_ot     = 3'(lo - ALU_BASE);
            end
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/exec/extension/write-back FSM with
// memory-ready handshake, halt/trap states and a retired-instruction counter.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int OPC_W = 4,
   parameter int LMAX  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [OPC_W-1:0] CS_opcode,
   input  logic             mem_ready,
   output logic [2:0]       CS_ALU_OT,
   output logic             CS_Ins_load,
   output logic             CS_PC_load,
   output logic             CS_PC_inc,
   output logic             CS_Op1_load,
   output logic             CS_Op2_load,
   output logic             CS_Reg_load,
   output logic             CS_halted,
   output logic             CS_illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int EXT_W = $clog2(LMAX);

   state_e           state, state_nxt;
   logic [OPC_W-1:0] op_q;
   logic [EXT_W-1:0] ext_cnt;
   logic             retire;

   logic [3:0] len_e, len_q;
   logic       wb_e, wb_q, ill_e, ill_q, hlt_e, hlt_q;
   dp_ctrl_t   exec_e, exec_q, wbc_e, wbc_q;
   dp_ctrl_t   dp;

   // Live opcode drives EXEC; the latched copy drives WB because the
   // opcode input is overwritten by extension-word fetches.
   ctrl_decode #(.OPC_W(OPC_W), .LMAX(LMAX)) u_dec_exec (
      .opcode   (CS_opcode),
      .length   (len_e),
      .needs_wb (wb_e),
      .illegal  (ill_e),
      .is_halt  (hlt_e),
      .exec_ctl (exec_e),
      .wb_ctl   (wbc_e)
   );

   ctrl_decode #(.OPC_W(OPC_W), .LMAX(LMAX)) u_dec_q (
      .opcode   (op_q),
      .length   (len_q),
      .needs_wb (wb_q),
      .illegal  (ill_q),
      .is_halt  (hlt_q),
      .exec_ctl (exec_q),
      .wb_ctl   (wbc_q)
   );

   logic dec_unused;
   assign dec_unused = ^{len_q, wb_q, ill_q, hlt_q, exec_q, wbc_e};

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         ST_RESET: state_nxt = ST_FETCH;
         ST_FETCH: if (mem_ready) state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (ill_e) begin
               state_nxt = ST_TRAP;
            end else if (hlt_e) begin
               state_nxt = ST_HALT;
               retire    = 1'b1;
            end else if (len_e > LEN_1) begin
               state_nxt = ST_EXT;
            end else if (wb_e) begin
               state_nxt = ST_WB;
            end else begin
               state_nxt = ST_FETCH;
               retire    = 1'b1;
            end
         end
         ST_EXT: if (mem_ready && ext_cnt == EXT_W'(1)) state_nxt = ST_WB;
         ST_WB: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
         end
         ST_HALT: state_nxt = ST_HALT;
         ST_TRAP: state_nxt = ST_TRAP;
         default: state_nxt = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RESET;
         op_q      <= '0;
         ext_cnt   <= '0;
         instr_cnt <= '0;
      end else if (!en) begin
         state <= ST_RESET;
      end else begin
         state <= state_nxt;
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
         if (state == ST_EXEC) begin
            op_q    <= CS_opcode;
            ext_cnt <= EXT_W'(len_e - LEN_1);
         end else if (state == ST_EXT && mem_ready) begin
            ext_cnt <= ext_cnt - EXT_W'(1);
         end
      end
   end

   always_comb begin
      dp          = '0;
      CS_Ins_load = 1'b0;
      CS_PC_load  = 1'b0;
      CS_PC_inc   = 1'b0;
      if (en) begin
         case (state)
            ST_FETCH, ST_EXT: begin
               CS_Ins_load = 1'b1;
               CS_PC_load  = 1'b1;
               CS_PC_inc   = mem_ready;
            end
            ST_EXEC: dp = exec_e;
            ST_WB:   dp = wbc_q;
            default: ;
         endcase
      end
   end

   assign CS_ALU_OT   = dp.alu_ot;
   assign CS_Op1_load = dp.op1_load;
   assign CS_Op2_load = dp.op2_load;
   assign CS_Reg_load = dp.reg_load;
   assign CS_halted   = (state == ST_HALT);
   assign CS_illegal  = (state == ST_TRAP);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: three sequencer configurations run in lockstep on shared
// inputs; directed vectors push expected outputs, a monitor pops and compares.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst, en, mem_ready;
   logic [4:0] op;

   logic [2:0]  ins, pcl, pci, o1, o2, rl, hl, il;
   logic [2:0]  alu [3];
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   always #5 clk = ~clk;

   control_sequencer #(.OPC_W(4), .LMAX(3), .CNT_W(16)) u_d0 (
      .clk(clk), .rst(rst), .en(en), .CS_opcode(op[3:0]), .mem_ready(mem_ready),
      .CS_ALU_OT(alu[0]), .CS_Ins_load(ins[0]), .CS_PC_load(pcl[0]), .CS_PC_inc(pci[0]),
      .CS_Op1_load(o1[0]), .CS_Op2_load(o2[0]), .CS_Reg_load(rl[0]),
      .CS_halted(hl[0]), .CS_illegal(il[0]), .instr_cnt(cnt0));

   control_sequencer #(.OPC_W(5), .LMAX(2), .CNT_W(16)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .CS_opcode(op), .mem_ready(mem_ready),
      .CS_ALU_OT(alu[1]), .CS_Ins_load(ins[1]), .CS_PC_load(pcl[1]), .CS_PC_inc(pci[1]),
      .CS_Op1_load(o1[1]), .CS_Op2_load(o2[1]), .CS_Reg_load(rl[1]),
      .CS_halted(hl[1]), .CS_illegal(il[1]), .instr_cnt(cnt1));

   control_sequencer #(.OPC_W(4), .LMAX(3), .CNT_W(4)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .CS_opcode(op[3:0]), .mem_ready(mem_ready),
      .CS_ALU_OT(alu[2]), .CS_Ins_load(ins[2]), .CS_PC_load(pcl[2]), .CS_PC_inc(pci[2]),
      .CS_Op1_load(o1[2]), .CS_Op2_load(o2[2]), .CS_Reg_load(rl[2]),
      .CS_halted(hl[2]), .CS_illegal(il[2]), .instr_cnt(cnt2));

   typedef struct {
      int          sel;
      string       nm;
      logic [5:0]  stb;
      logic [2:0]  alu;
      logic        h;
      logic        il;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // stb = {Ins_load, PC_load, PC_inc, Op1_load, Op2_load, Reg_load}
   localparam logic [5:0] Z  = 6'b000000;
   localparam logic [5:0] F1 = 6'b111000;
   localparam logic [5:0] F0 = 6'b110000;

   exp_t        e;
   logic [5:0]  a_stb;
   logic [2:0]  a_alu;
   logic        a_h, a_il;
   logic [15:0] a_cnt;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         e     = q.pop_front();
         a_stb = {ins[e.sel], pcl[e.sel], pci[e.sel], o1[e.sel], o2[e.sel], rl[e.sel]};
         a_alu = alu[e.sel];
         a_h   = hl[e.sel];
         a_il  = il[e.sel];
         a_cnt = (e.sel == 0) ? cnt0 : (e.sel == 1) ? cnt1 : 16'(cnt2);
         vectors++;
         if ({a_stb, a_alu, a_h, a_il, a_cnt} !== {e.stb, e.alu, e.h, e.il, e.cnt}) begin
            miscompares++;
            $display("FAIL %s dut%0d: got stb=%b alu=%0d halted=%b illegal=%b cnt=%0d, want stb=%b alu=%0d halted=%b illegal=%b cnt=%0d",
                     e.nm, e.sel, a_stb, a_alu, a_h, a_il, a_cnt, e.stb, e.alu, e.h, e.il, e.cnt);
         end
      end
   end

   task automatic drive(input bit e_i, input logic [4:0] o, input bit mr);
      @(posedge clk); #1;
      rst = 1'b0; en = e_i; op = o; mem_ready = mr;
   endtask

   task automatic drive_rst();
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; op = 5'h0; mem_ready = 1'b1;
   endtask

   task automatic ex(input int s, input string nm, input logic [5:0] stb,
                     input logic [2:0] a, input bit h, input bit i, input int c);
      exp_t x;
      x.sel = s; x.nm = nm; x.stb = stb; x.alu = a; x.h = h; x.il = i; x.cnt = 16'(c);
      q.push_back(x);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; op = 5'h0; mem_ready = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) ex(s, "reset", Z, 0, 0, 0, 0);

      // MOV
      drive(1, 5'h0, 1); ex(0, "mov_reset", Z, 0, 0, 0, 0);
      drive(1, 5'h0, 1); ex(0, "mov_fetch", F1, 0, 0, 0, 0);
      drive(1, 5'h0, 1); ex(0, "mov_exec", 6'b000011, 0, 0, 0, 0);
      drive(1, 5'h0, 0); ex(0, "mov_retired_stall", F0, 0, 0, 0, 1);
      // MVI, stalled extension fetch, opcode bus overwritten with 0xD
      drive(1, 5'h0, 1); ex(0, "mvi_fetch", F1, 0, 0, 0, 1);
      drive(1, 5'h1, 1); ex(0, "mvi_exec", 6'b000100, 0, 0, 0, 1);
      drive(1, 5'hD, 0); ex(0, "mvi_ext_wait1", F0, 0, 0, 0, 1);
      drive(1, 5'hD, 0); ex(0, "mvi_ext_wait2", F0, 0, 0, 0, 1);
      drive(1, 5'hD, 1); ex(0, "mvi_ext_ready", F1, 0, 0, 0, 1);
      drive(1, 5'hD, 1); ex(0, "mvi_wb", 6'b000001, 0, 0, 0, 1);
      // ADD then XOR
      drive(1, 5'h0, 1); ex(0, "add_fetch", F1, 0, 0, 0, 2);
      drive(1, 5'h4, 1); ex(0, "add_exec", 6'b000110, 0, 0, 0, 2);
      drive(1, 5'hD, 1); ex(0, "add_wb", 6'b000001, 0, 0, 0, 2);
      drive(1, 5'h0, 1); ex(0, "xor_fetch", F1, 0, 0, 0, 3);
      drive(1, 5'h8, 1); ex(0, "xor_exec", 6'b000110, 4, 0, 0, 3);
      drive(1, 5'h0, 1); ex(0, "xor_wb", 6'b000001, 4, 0, 0, 3);
      // LDX: legal with LMAX=3, trap with LMAX=2
      drive(1, 5'h0, 1); ex(0, "ldx_fetch", F1, 0, 0, 0, 4);
      drive(1, 5'h3, 1); ex(0, "ldx_exec", Z, 0, 0, 0, 4);
      drive(1, 5'h0, 1); ex(0, "ldx_ext1", F1, 0, 0, 0, 4); ex(1, "ldx_trap1", Z, 0, 0, 1, 4);
      drive(1, 5'h0, 1); ex(0, "ldx_ext2", F1, 0, 0, 0, 4); ex(1, "ldx_trap2", Z, 0, 0, 1, 4);
      drive(1, 5'h0, 0); ex(0, "ldx_wb", 6'b000101, 0, 0, 0, 4); ex(1, "ldx_trap3", Z, 0, 0, 1, 4);
      // HLT
      drive(1, 5'h0, 1); ex(0, "hlt_fetch", F1, 0, 0, 0, 5); ex(2, "hlt_fetch_c4", F1, 0, 0, 0, 5);
      drive(1, 5'hE, 1); ex(0, "hlt_exec", Z, 0, 0, 0, 5);
      drive(1, 5'hE, 0); ex(0, "halted_mr0", Z, 0, 1, 0, 6);
      drive(1, 5'hE, 1); ex(0, "halted_mr1", Z, 0, 1, 0, 6); ex(1, "trap_held", Z, 0, 0, 1, 4);
      drive(0, 5'hE, 1); ex(0, "halted_en_low", Z, 0, 1, 0, 6); ex(1, "trap_en_low", Z, 0, 0, 1, 4);
      drive(1, 5'h0, 1); ex(0, "resume_reset", Z, 0, 0, 0, 6); ex(1, "trap_cleared", Z, 0, 0, 0, 4);
      drive(1, 5'h0, 1); ex(0, "resume_fetch", F1, 0, 0, 0, 6);
      // 0x14: ADD on 4-bit opcode DUTs, illegal upper bit on 5-bit DUT
      drive(1, 5'h14, 1); ex(0, "add_low4", 6'b000110, 0, 0, 0, 6); ex(1, "upper_exec", Z, 0, 0, 0, 4);
      drive(1, 5'h0, 1); ex(0, "add_low4_wb", 6'b000001, 0, 0, 0, 6); ex(1, "upper_trap", Z, 0, 0, 1, 4);
      // en=0 mid-EXT abandons LDA
      drive(1, 5'h0, 1); ex(0, "lda_fetch", F1, 0, 0, 0, 7);
      drive(1, 5'h2, 1); ex(0, "lda_exec", Z, 0, 0, 0, 7);
      drive(1, 5'h0, 0); ex(0, "lda_ext_wait", F0, 0, 0, 0, 7);
      drive(0, 5'h0, 1); ex(0, "ext_en_low", Z, 0, 0, 0, 7);
      drive(1, 5'h0, 1); ex(0, "abandon_reset", Z, 0, 0, 0, 7);
      drive(1, 5'h0, 1); ex(0, "abandon_fetch", F1, 0, 0, 0, 7);
      // rst and en=0 together: rst wins and clears the counter
      drive_rst();       ex(0, "rst_en_cycle", Z, 0, 0, 0, 7);
      drive(1, 5'h0, 1);
      for (int s = 0; s < 3; s++) ex(s, "rst_wins", Z, 0, 0, 0, 0);
      // 16 NOPs wrap the 4-bit counter
      for (int k = 0; k < 16; k++) begin
         drive(1, 5'h0, 1); ex(2, "nop_fetch", F1, 0, 0, 0, k);
         drive(1, 5'hC, 1); ex(2, "nop_exec", Z, 0, 0, 0, k);
      end
      drive(1, 5'h0, 0);
      ex(2, "cnt4_wrap", F0, 0, 0, 0, 0);
      ex(0, "cnt16_nops", F0, 0, 0, 0, 16);
      ex(1, "cnt16_nops_d1", F0, 0, 0, 0, 16);

      @(negedge clk); #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
